// File: rtl/risc_mem_pkg.sv
// Shared definitions for the RISC_PROC data memory: clear FSM states,
// default geometry and the byte-lane count helper.
package risc_mem_pkg;

  localparam int WIDTH_DEF = 16;
  localparam int DEPTH_DEF = 64;

  typedef enum logic {
    S_IDLE,
    S_CLEAR
  } state_t;

  function automatic int lanes(input int w);
    return w / 8;
  endfunction

endpackage

// File: rtl/dmem_clear_ctrl.sv
// Power-on clear sequencer: sweeps word k at cycle k after rst falls.
// Ports: clk, rst (sync, active high); busy, clr_we, clr_addr out.
module dmem_clear_ctrl
  import risc_mem_pkg::*;
#(
  parameter int DEPTH  = DEPTH_DEF,
  parameter int AW_IDX = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  output logic              busy,
  output logic              clr_we,
  output logic [AW_IDX-1:0] clr_addr
);

  localparam logic [AW_IDX-1:0] LAST = AW_IDX'(DEPTH - 1);

  state_t            state;
  logic [AW_IDX-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_CLEAR;
      cnt   <= '0;
    end else begin
      unique case (state)
        S_CLEAR: begin
          cnt <= cnt + 1'b1;
          if (cnt == LAST)
            state <= S_IDLE;
        end
        S_IDLE: begin
          cnt <= '0;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // No sweep writes while rst is held; the sweep starts
  // with word 0 in the first cycle after rst falls.
  assign busy     = (state == S_CLEAR);
  assign clr_we   = busy & ~rst;
  assign clr_addr = cnt;

endmodule

// File: rtl/data_memory_sync.sv
// Clocked single-port data memory with valid/ready request port,
// per-byte write enables, 1-cycle response and out-of-range error.
// Ports: clk, rst (sync, active high); req_valid/ready/we/be/addr/
// wdata in; rsp_valid/rdata/err out.
// Optional: DATA_MEMORY_SYNC_CLEAR_EN zeroes the array after reset.
module data_memory_sync
  import risc_mem_pkg::*;
#(
  parameter int WIDTH  = WIDTH_DEF,
  parameter int DEPTH  = DEPTH_DEF,
  parameter int ADDR_W = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [WIDTH/8-1:0]    req_be,
  input  logic [ADDR_W-1:0]     req_addr,
  input  logic [WIDTH-1:0]      req_wdata,
  output logic                  rsp_valid,
  output logic [WIDTH-1:0]      rsp_rdata,
  output logic                  rsp_err
);

  localparam int NB     = lanes(WIDTH);
  localparam int AW_IDX = $clog2(DEPTH);
  localparam logic [ADDR_W-1:0] LIMIT = ADDR_W'(DEPTH);

  logic              busy;
  logic              clr_we;
  logic [AW_IDX-1:0] clr_addr;

`ifdef DATA_MEMORY_SYNC_CLEAR_EN
  dmem_clear_ctrl #(
    .DEPTH  (DEPTH),
    .AW_IDX (AW_IDX)
  ) u_clr (
    .clk      (clk),
    .rst      (rst),
    .busy     (busy),
    .clr_we   (clr_we),
    .clr_addr (clr_addr)
  );
`else
  assign busy     = 1'b0;
  assign clr_we   = 1'b0;
  assign clr_addr = '0;
`endif

  logic              accept;
  logic              in_range;
  logic              wr_en;
  logic              rd_en;
  logic [AW_IDX-1:0] idx;

  assign req_ready = ~rst & ~busy;
  assign accept    = req_valid & req_ready;
  // Full-width compare so high address bits never alias.
  assign in_range  = (req_addr < LIMIT);
  assign idx       = req_addr[AW_IDX-1:0];
  assign wr_en     = accept & req_we & in_range;
  assign rd_en     = accept & ~req_we & in_range;

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (clr_we) begin
      mem[clr_addr] <= '0;
    end else if (wr_en) begin
      for (int i = 0; i < NB; i++) begin
        if (req_be[i])
          mem[idx][i*8 +: 8] <= req_wdata[i*8 +: 8];
      end
    end
  end

  logic             valid_q;
  logic [WIDTH-1:0] rdata_q;
  logic             err_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      valid_q <= accept;
      err_q   <= accept & ~in_range;
      rdata_q <= rd_en ? mem[idx] : '0;
    end
  end

  // A response in flight when rst rises is dropped at once.
  assign rsp_valid = valid_q & ~rst;
  assign rsp_rdata = rst ? '0 : rdata_q;
  assign rsp_err   = err_q & ~rst;

endmodule

// File: tb/tb_data_memory_sync.sv
// Scoreboard bench for data_memory_sync: driver pushes expected
// responses, a negedge monitor pops and compares.
module tb_data_memory_sync;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic [1:0]  req_be = 2'b00;
  logic [15:0] req_addr = 16'h0;
  logic [15:0] req_wdata = 16'h0;
  logic        rsp_valid;
  logic [15:0] rsp_rdata;
  logic        rsp_err;

  int checks = 0;
  int errors = 0;
  bit mon_en = 1'b0;
  logic [16:0] sb [$];

  always #5 clk = ~clk;

  data_memory_sync dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_we    (req_we),
    .req_be    (req_be),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .rsp_valid (rsp_valid),
    .rsp_rdata (rsp_rdata),
    .rsp_err   (rsp_err)
  );

  always @(negedge clk) begin
    if (mon_en) begin
      checks++;
      if (rsp_valid) begin
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL unexpected_rsp: got rdata=%h err=%b, required no response",
                   rsp_rdata, rsp_err);
        end else begin
          logic [16:0] e;
          e = sb.pop_front();
          if ({rsp_err, rsp_rdata} !== e) begin
            errors++;
            $display("FAIL rsp: got err=%b rdata=%h, required err=%b rdata=%h",
                     rsp_err, rsp_rdata, e[16], e[15:0]);
          end
        end
      end else if (rsp_rdata !== 16'h0 || rsp_err !== 1'b0) begin
        errors++;
        $display("FAIL idle_outputs: got rdata=%h err=%b, required 0 0",
                 rsp_rdata, rsp_err);
      end
    end
  end

  task automatic issue(input bit we, input logic [1:0] be,
                       input logic [15:0] a, input logic [15:0] wd,
                       input logic [15:0] er, input bit ee,
                       input bit push);
    int n = 0;
    req_valid = 1'b1;
    req_we    = we;
    req_be    = be;
    req_addr  = a;
    req_wdata = wd;
    while (!req_ready && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    if (!req_ready) begin
      checks++;
      errors++;
      $display("FAIL ready_timeout: got ready=0, required 1");
      req_valid = 1'b0;
      return;
    end
    if (push) sb.push_back({ee, er});
    @(posedge clk); #1;
  endtask

  task automatic idle(input int n);
    req_valid = 1'b0;
    req_we    = 1'b0;
    req_be    = 2'b00;
    repeat (n) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic check(input string nm, input logic [31:0] got,
                       input logic [31:0] req);
    checks++;
    if (got !== req) begin
      errors++;
      $display("FAIL %s: got %0h, required %0h", nm, got, req);
    end
  endtask

  // Releases rst and measures how many cycles ready stays low.
  task automatic release_rst(output int lowcnt);
    lowcnt = 0;
    rst = 1'b0;
    forever begin
      @(negedge clk);
      if (req_ready || lowcnt >= 300) break;
      lowcnt++;
    end
    @(posedge clk); #1;
  endtask

  initial begin
    int n;
    repeat (2) @(posedge clk);
    #1;
    mon_en = 1'b1;
    @(negedge clk);
    check("ready_in_rst", 32'(req_ready), 32'd0);
    check("valid_in_rst", 32'(rsp_valid), 32'd0);
    @(posedge clk); #1;
    release_rst(n);
`ifdef DATA_MEMORY_SYNC_CLEAR_EN
    check("clear_len", 32'(n), 32'd64);
    issue(0, 2'b00, 16'd63, 16'h0, 16'h0000, 0, 1);
`else
    check("ready_after_rst", 32'(n), 32'd0);
`endif

    issue(1, 2'b11, 16'd5, 16'hBEEF, 16'h0000, 0, 1);
    issue(0, 2'b00, 16'd5, 16'h0,    16'hBEEF, 0, 1);
    issue(1, 2'b01, 16'd5, 16'h0012, 16'h0000, 0, 1);
    issue(0, 2'b00, 16'd5, 16'h0,    16'hBE12, 0, 1);

    issue(1, 2'b11, 16'd0,    16'h1234, 16'h0000, 0, 1);
    issue(0, 2'b00, 16'd64,   16'h0,    16'h0000, 1, 1);
    issue(0, 2'b00, 16'd0,    16'h0,    16'h1234, 0, 1);
    issue(1, 2'b11, 16'd69,   16'hDEAD, 16'h0000, 1, 1);
    issue(0, 2'b00, 16'hFFC5, 16'h0,    16'h0000, 1, 1);
    issue(0, 2'b00, 16'd5,    16'h0,    16'hBE12, 0, 1);
    idle(2);

    for (int i = 0; i < 8; i++)
      issue(1, 2'b11, 16'(i), 16'(16'h10 + i), 16'h0, 0, 1);
    for (int i = 0; i < 8; i++)
      issue(0, 2'b00, 16'(i), 16'h0, 16'(16'h10 + i), 0, 1);
    issue(1, 2'b10, 16'd7, 16'hAB99, 16'h0000, 0, 1);
    issue(0, 2'b00, 16'd7, 16'h0,    16'hAB17, 0, 1);
    idle(3);
    check("sb_drained", 32'(sb.size()), 32'd0);

    issue(0, 2'b00, 16'd3, 16'h0, 16'h0, 0, 0);
    req_valid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    check("rst_drop_valid", 32'(rsp_valid), 32'd0);
    check("rst_drop_rdata", 32'(rsp_rdata), 32'd0);
    check("rst_ready", 32'(req_ready), 32'd0);
    @(posedge clk); #1;
    release_rst(n);
`ifdef DATA_MEMORY_SYNC_CLEAR_EN
    check("clear_len2", 32'(n), 32'd64);
    issue(0, 2'b00, 16'd63, 16'h0, 16'h0000, 0, 1);
    issue(0, 2'b00, 16'd5,  16'h0, 16'h0000, 0, 1);
    issue(1, 2'b11, 16'd9,  16'h5A5A, 16'h0000, 0, 1);
    idle(1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (30) begin
      @(posedge clk); #1;
    end
    rst = 1'b1;
    @(posedge clk); #1;
    release_rst(n);
    check("clear_restart", 32'(n), 32'd64);
    issue(0, 2'b00, 16'd9, 16'h0, 16'h0000, 0, 1);
`else
    check("ready_after_rst2", 32'(n), 32'd0);
    issue(0, 2'b00, 16'd3, 16'h0, 16'h0013, 0, 1);
`endif
    idle(3);
    check("sb_final", 32'(sb.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
